// File: rtl/pong_pkg.sv
// pong_pkg
//  Shared definitions for the Pong game-flow controller and its score display:
//  fixed game_state codes, score width, winner codes and the 7-segment hex table.
//  The hex table drives active-low segments packed as {g,f,e,d,c,b,a}.

package pong_pkg;

    localparam int SCORE_W = 4;

    // game_state codes are visible on the port, so the encoding is pinned here
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Hex digit to active-low segment pattern {g..a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/pong_seg_mux.sv
// pong_seg_mux
//  Scans the two player scores onto a 4-digit multiplexed 7-segment display.
//  A free-running divider's top two bits pick the digit: an[0] shows score1,
//  an[3] shows score2, an[2:1] are enabled in turn but blanked. seg and an are
//  registered so the display outputs are glitch-free.
// Ports
//  clk     in   1          system clock
//  rst     in   1          synchronous active-high reset (clears divider, blanks display)
//  score1  in   SCORE_W    player 1 score
//  score2  in   SCORE_W    player 2 score
//  seg     out  7          segments, active low, {g..a}
//  an      out  4          digit enables, active low, one at a time

module pong_seg_mux
    import pong_pkg::*;
#(
    parameter int SEG_DIV_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    logic [SEG_DIV_W-1:0] div;
    logic [1:0]           digit_sel;

    assign digit_sel = div[SEG_DIV_W-1 -: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            div <= div + 1'b1;
            case (digit_sel)
                2'd0: begin
                    an  <= 4'b1110;
                    seg <= hex_to_seg(score1);
                end
                2'd1: begin
                    an  <= 4'b1101;
                    seg <= SEG_BLANK;
                end
                2'd2: begin
                    an  <= 4'b1011;
                    seg <= SEG_BLANK;
                end
                default: begin
                    an  <= 4'b0111;
                    seg <= hex_to_seg(score2);
                end
            endcase
        end
    end

endmodule

// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl
//  Game-flow controller for Pong. Samples ball_x once per frame, detects goals,
//  keeps both scores and sequences IDLE -> SERVE -> PLAY -> POINT/OVER.
//  Drives ball freeze and the one-cycle serve command back to the Ball block.
//  Every output is registered.
// Configuration
//  SCORE_SEG_EN : when defined, a pong_seg_mux instance scans the scores onto a
//                 4-digit 7-segment display (SEG_DIV_W sets the scan divider width).
//                 When undefined, seg is tied to 7'h7F and an to 4'hF.
// Ports
//  clk         in   1   system clock
//  rst         in   1   synchronous active-high reset, overrides all inputs
//  frame_tick  in   1   one-cycle pulse per video frame
//  ball_x      in   10  ball left-edge X
//  start       in   1   start/restart request (level, rising edge used)
//  ball_freeze out  1   1 = ball holds position
//  ball_serve  out  1   one-cycle pulse: ball reloads to centre and launches
//  serve_dir   out  1   launch direction, 1 = right, 0 = left
//  score1      out  4   player 1 score (defends the right end)
//  score2      out  4   player 2 score (defends the left end)
//  winner      out  2   00 none, 01 P1, 10 P2
//  game_state  out  3   current state code
//  seg         out  7   segments, active low {g..a}
//  an          out  4   digit enables, active low

module pong_score_ctrl
    import pong_pkg::*;
#(
    parameter logic [9:0]         LEFT_GOAL_X  = 10'd2,
    parameter logic [9:0]         RIGHT_GOAL_X = 10'd620,
    parameter logic [SCORE_W-1:0] WIN_SCORE    = 4'd7,
    parameter logic [7:0]         SERVE_FRAMES = 8'd60,
    parameter logic [7:0]         POINT_FRAMES = 8'd90
`ifdef SCORE_SEG_EN
    ,
    parameter int                 SEG_DIV_W    = 17
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [9:0]         ball_x,
    input  logic               start,
    output logic               ball_freeze,
    output logic               ball_serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         game_state,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    state_t             state, state_next;
    logic [7:0]         cnt, cnt_next;
    logic [SCORE_W-1:0] score1_next, score2_next;
    logic [SCORE_W-1:0] score1_inc, score2_inc;
    logic [1:0]         winner_next;
    logic               freeze_next, serve_next, dir_next;
    logic               start_q, start_rise;

    assign start_rise = start & ~start_q;
    assign score1_inc = score1 + 1'b1;
    assign score2_inc = score2 + 1'b1;
    assign game_state = state;

    // State, counter, score and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            score1      <= '0;
            score2      <= '0;
            winner      <= WIN_NONE;
            ball_freeze <= 1'b1;
            ball_serve  <= 1'b0;
            serve_dir   <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            score1      <= score1_next;
            score2      <= score2_next;
            winner      <= winner_next;
            ball_freeze <= freeze_next;
            ball_serve  <= serve_next;
            serve_dir   <= dir_next;
            start_q     <= start;
        end
    end

    // Next-state logic. A start edge in IDLE/OVER wins over a same-cycle frame
    // tick because the tick is simply not looked at in those states. The frame
    // counters test cnt <= 1 so a counter that somehow reached 0 still advances.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        score1_next = score1;
        score2_next = score2;
        winner_next = winner;
        freeze_next = ball_freeze;
        serve_next  = 1'b0;
        dir_next    = serve_dir;

        case (state)
            ST_IDLE, ST_OVER: begin
                freeze_next = 1'b1;
                if (start_rise) begin
                    state_next  = ST_SERVE;
                    score1_next = '0;
                    score2_next = '0;
                    winner_next = WIN_NONE;
                    cnt_next    = SERVE_FRAMES;
                    dir_next    = 1'b1;
                end
            end

            ST_SERVE: begin
                freeze_next = 1'b1;
                if (frame_tick) begin
                    if (cnt <= 8'd1) begin
                        state_next  = ST_PLAY;
                        serve_next  = 1'b1;
                        freeze_next = 1'b0;
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
            end

            ST_PLAY: begin
                freeze_next = 1'b0;
                if (frame_tick) begin
                    // Left end is checked first; the conceding side receives the serve
                    if (ball_x <= LEFT_GOAL_X) begin
                        score1_next = score1_inc;
                        dir_next    = 1'b0;
                        freeze_next = 1'b1;
                        if (score1_inc == WIN_SCORE) begin
                            state_next  = ST_OVER;
                            winner_next = WIN_P1;
                        end else begin
                            state_next = ST_POINT;
                            cnt_next   = POINT_FRAMES;
                        end
                    end else if (ball_x >= RIGHT_GOAL_X) begin
                        score2_next = score2_inc;
                        dir_next    = 1'b1;
                        freeze_next = 1'b1;
                        if (score2_inc == WIN_SCORE) begin
                            state_next  = ST_OVER;
                            winner_next = WIN_P2;
                        end else begin
                            state_next = ST_POINT;
                            cnt_next   = POINT_FRAMES;
                        end
                    end
                end
            end

            ST_POINT: begin
                freeze_next = 1'b1;
                if (frame_tick) begin
                    if (cnt <= 8'd1) begin
                        state_next = ST_SERVE;
                        cnt_next   = SERVE_FRAMES;
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
            end

            default: begin
                state_next  = ST_IDLE;
                freeze_next = 1'b1;
            end
        endcase
    end

`ifdef SCORE_SEG_EN
    pong_seg_mux #(
        .SEG_DIV_W (SEG_DIV_W)
    ) u_seg_mux (
        .clk    (clk),
        .rst    (rst),
        .score1 (score1),
        .score2 (score2),
        .seg    (seg),
        .an     (an)
    );
`else
    assign seg = SEG_BLANK;
    assign an  = AN_OFF;
`endif

endmodule
